// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-clock divider, x/y coordinates, registered sync/blank decodes and line/frame pulses.
// Optional macro VGA_FRAME_CNT_EN builds an 8-bit frame counter; otherwise frame_cnt is tied to zero.
module vga_sync_gen #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_VIS    = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SW     = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_VIS    = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SW     = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned SYNC_POL = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       pix_tick,
   output logic [9:0] counter_x,
   output logic [9:0] counter_y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_cnt
);

   localparam int unsigned H_TOT = H_VIS + H_FP + H_SW + H_BP;
   localparam int unsigned V_TOT = V_VIS + V_FP + V_SW + V_BP;

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
   localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
   localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
   localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SW);
   localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SW);
   localparam logic       SYNC_ON  = 1'(SYNC_POL);
   localparam logic       SYNC_OFF = ~SYNC_ON;

   logic [3:0] div_q, div_d;
   logic [9:0] x_q, x_d, y_q, y_d;
   logic       pix_tick_q, pix_tick_d;
   logic       hsync_q, hsync_d, vsync_q, vsync_d;
   logic       video_on_q, video_on_d;
   logic       line_start_q, line_start_d;
   logic       frame_start_q, frame_start_d;
   logic       div_wrap_s;
   logic [9:0] x_next_s, y_next_s;

   // Next-state: decodes are computed from the advancing coordinates so they land with them.
   always_comb begin
      div_wrap_s = (div_q == DIV_LAST);
      div_d      = div_wrap_s ? 4'd0 : (div_q + 4'd1);
      pix_tick_d = div_wrap_s;

      x_next_s = (x_q == H_LAST) ? 10'd0 : (x_q + 10'd1);
      if (x_q == H_LAST) begin
         y_next_s = (y_q == V_LAST) ? 10'd0 : (y_q + 10'd1);
      end else begin
         y_next_s = y_q;
      end

      x_d           = x_q;
      y_d           = y_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      video_on_d    = video_on_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;

      if (div_wrap_s) begin
         x_d           = x_next_s;
         y_d           = y_next_s;
         hsync_d       = ((x_next_s >= HS_BEG) && (x_next_s < HS_END)) ? SYNC_ON : SYNC_OFF;
         vsync_d       = ((y_next_s >= VS_BEG) && (y_next_s < VS_END)) ? SYNC_ON : SYNC_OFF;
         video_on_d    = (x_next_s < H_VIS_W) && (y_next_s < V_VIS_W);
         line_start_d  = (x_next_s == 10'd0);
         frame_start_d = (x_next_s == 10'd0) && (y_next_s == 10'd0);
      end else begin
         line_start_d  = 1'b0;
         frame_start_d = 1'b0;
      end
   end

   // Raster state register; reset aborts any sync pulse in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q         <= 4'd0;
         x_q           <= 10'd0;
         y_q           <= 10'd0;
         pix_tick_q    <= 1'b0;
         hsync_q       <= SYNC_OFF;
         vsync_q       <= SYNC_OFF;
         video_on_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         x_q           <= x_d;
         y_q           <= y_d;
         pix_tick_q    <= pix_tick_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame_cnt_q, frame_cnt_d;

   // Count advances on the same edge that raises frame_start; wraps naturally at 8 bits.
   always_comb begin
      if (frame_start_d) begin
         frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
         frame_cnt_d = frame_cnt_q;
      end
   end

   // Frame counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt_q <= 8'd0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = 8'd0;
`endif

   assign pix_tick    = pix_tick_q;
   assign counter_x   = x_q;
   assign counter_y   = y_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: two shrunken-raster instances (divide-by-2 active-low,
// divide-by-1 active-high) checked every cycle against an arithmetic model of the raster.
module tb_vga_sync_gen;

   localparam int HV = 8,  HFP = 2, HSW = 3, HBP = 2;
   localparam int VV = 4,  VFP = 1, VSW = 2, VBP = 1;
   localparam int HT = HV + HFP + HSW + HBP;
   localparam int VT = VV + VFP + VSW + VBP;
`ifdef VGA_FRAME_CNT_EN
   localparam bit FC_EN = 1'b1;
`else
   localparam bit FC_EN = 1'b0;
`endif

   typedef struct packed {
      logic       tick;
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       vo;
      logic       ls;
      logic       fs;
      logic [7:0] fc;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       a_tick, a_hs, a_vs, a_vo, a_ls, a_fs;
   logic [9:0] a_x, a_y;
   logic [7:0] a_fc;
   logic       b_tick, b_hs, b_vs, b_vo, b_ls, b_fs;
   logic [9:0] b_x, b_y;
   logic [7:0] b_fc;

   vga_sync_gen #(.CLK_DIV(2), .H_VIS(HV), .H_FP(HFP), .H_SW(HSW), .H_BP(HBP),
                  .V_VIS(VV), .V_FP(VFP), .V_SW(VSW), .V_BP(VBP), .SYNC_POL(0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .pix_tick(a_tick), .counter_x(a_x), .counter_y(a_y),
      .hsync(a_hs), .vsync(a_vs), .video_on(a_vo), .line_start(a_ls),
      .frame_start(a_fs), .frame_cnt(a_fc));

   vga_sync_gen #(.CLK_DIV(1), .H_VIS(HV), .H_FP(HFP), .H_SW(HSW), .H_BP(HBP),
                  .V_VIS(VV), .V_FP(VFP), .V_SW(VSW), .V_BP(VBP), .SYNC_POL(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .pix_tick(b_tick), .counter_x(b_x), .counter_y(b_y),
      .hsync(b_hs), .vsync(b_vs), .video_on(b_vo), .line_start(b_ls),
      .frame_start(b_fs), .frame_cnt(b_fc));

   // Expected outputs k clocks after reset release (k=0: the reset state itself).
   function automatic obs_t model(input int k, input int div, input bit pol);
      obs_t o;
      int p, x, y;
      o = '0;
      o.hs = ~pol;
      o.vs = ~pol;
      if (k == 0) return o;
      p = k / div;
      x = p % HT;
      y = (p / HT) % VT;
      o.tick = ((k % div) == 0);
      o.x    = 10'(x);
      o.y    = 10'(y);
      o.hs   = (x >= HV + HFP && x < HV + HFP + HSW) ? pol : ~pol;
      o.vs   = (y >= VV + VFP && y < VV + VFP + VSW) ? pol : ~pol;
      o.vo   = (p > 0) && (x < HV) && (y < VV);
      o.ls   = o.tick && (x == 0);
      o.fs   = o.tick && (x == 0) && (y == 0);
      o.fc   = FC_EN ? 8'((p / (HT * VT)) % 256) : 8'd0;
      return o;
   endfunction

   obs_t q_a[$];
   obs_t q_b[$];
   int   k = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   tmo_flag = 1'b0;
   bit   tmo_seen = 1'b0;

   // Stimulus-side model: one expected observation per clock per instance.
   always @(posedge clk) begin
      if (!rst_n) k = 0;
      else k = k + 1;
      q_a.push_back(model(k, 2, 1'b0));
      q_b.push_back(model(k, 1, 1'b1));
   end

   // Monitor: pops expectations and compares against the settled outputs mid-cycle.
   always @(negedge clk) begin
      obs_t e, g;
      if (q_a.size() > 0) begin
         e = q_a.pop_front();
         g = '{a_tick, a_x, a_y, a_hs, a_vs, a_vo, a_ls, a_fs, a_fc};
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL dut_a t=%0t got tick=%b x=%0d y=%0d hs=%b vs=%b vo=%b ls=%b fs=%b fc=%0d required tick=%b x=%0d y=%0d hs=%b vs=%b vo=%b ls=%b fs=%b fc=%0d",
                     $time, g.tick, g.x, g.y, g.hs, g.vs, g.vo, g.ls, g.fs, g.fc,
                     e.tick, e.x, e.y, e.hs, e.vs, e.vo, e.ls, e.fs, e.fc);
         end
      end
      if (q_b.size() > 0) begin
         e = q_b.pop_front();
         g = '{b_tick, b_x, b_y, b_hs, b_vs, b_vo, b_ls, b_fs, b_fc};
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL dut_b t=%0t got tick=%b x=%0d y=%0d hs=%b vs=%b vo=%b ls=%b fs=%b fc=%0d required tick=%b x=%0d y=%0d hs=%b vs=%b vo=%b ls=%b fs=%b fc=%0d",
                     $time, g.tick, g.x, g.y, g.hs, g.vs, g.vo, g.ls, g.fs, g.fc,
                     e.tick, e.x, e.y, e.hs, e.vs, e.vo, e.ls, e.fs, e.fc);
         end
      end
      if (tmo_flag && !tmo_seen) begin
         tmo_seen = 1'b1;
         n_checks++;
         n_fail++;
         $display("FAIL sync_window_wait got no overlap of hsync/vsync within budget required overlap");
      end
   end

   initial begin
      bit found;
      rst_n = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b1;

      // Random run lengths interleaved with random-length resets.
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(1, 400)) @(posedge clk);
         #1 rst_n = 1'b0;
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1 rst_n = 1'b1;
      end

      // Reset while the active-high instance is inside both sync windows.
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk);
         if (b_hs === 1'b1 && b_vs === 1'b1) found = 1'b1;
      end
      if (!found) tmo_flag = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Long undisturbed run: more than 256 frames on the divide-by-1 instance.
      repeat (31000) @(posedge clk);
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
